sum_window_avg: RTL and testbench

SUM_WINDOW_AVG -- requirements
Module: sum_window_avg

---
 rtl/sum_window_avg_if.sv | 20 ++
 rtl/sum_window_avg.sv | 123 ++++++++++++
 tb/tb_sum_window_avg.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sum_window_avg_if.sv
// Pin bundle for sum_window_avg: enable, sample byte, control bits
// (ui_in/uio_in) and result/status bytes (uo_out/uio_out/uio_oe).
interface sum_window_avg_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/sum_window_avg.sv
// Windowed average/max of 2**WINDOW_LOG2 unsigned byte samples.
// Ports: clk, rst_n (sync, active-low), bus (slave side of sum_window_avg_if).
module sum_window_avg #(
  parameter int WINDOW_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  sum_window_avg_if.slave bus
);

  localparam int AW = 8 + WINDOW_LOG2;
  localparam int CW = WINDOW_LOG2 + 1;
  localparam logic [CW-1:0] LAST =
    CW'((1 << WINDOW_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] acc, acc_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    max_q, max_n;
  logic [7:0]    avg_q, avg_n;
  logic          done_q, done_n;

  logic in_valid, ack, clear, out_sel;
  logic ready, busy;
  logic [AW-1:0] sum;
  logic [7:0]    max_in;
  logic          unused_bits;

  assign in_valid = bus.uio_in[0];
  assign ack      = bus.uio_in[1];
  assign clear    = bus.uio_in[2];
  assign out_sel  = bus.uio_in[3];
  assign unused_bits = ^bus.uio_in[7:4];

  assign ready  = (state != HOLD);
  assign busy   = (state != IDLE);
  assign sum    = acc + AW'(bus.ui_in);
  assign max_in = (bus.ui_in > max_q) ?
                  bus.ui_in : max_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      max_q  <= '0;
      avg_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      max_q  <= max_n;
      avg_q  <= avg_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    max_n   = max_q;
    avg_n   = avg_q;
    done_n  = done_q;
    if (bus.ena) begin
      if (clear) begin
        state_n = IDLE;
        acc_n   = '0;
        cnt_n   = '0;
        max_n   = '0;
        avg_n   = '0;
        done_n  = 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (in_valid) begin
              acc_n   = sum;
              cnt_n   = cnt + 1'b1;
              max_n   = max_in;
              state_n = ACCUM;
            end
          end
          ACCUM: begin
            if (in_valid) begin
              acc_n = sum;
              cnt_n = cnt + 1'b1;
              max_n = max_in;
              // final sample of the window
              if (cnt == LAST) begin
                state_n = HOLD;
                avg_n   = sum[WINDOW_LOG2 +: 8];
                done_n  = 1'b1;
              end
            end
          end
          HOLD: begin
            // avg survives ack; only clear/reset zero it
            if (ack) begin
              state_n = IDLE;
              acc_n   = '0;
              cnt_n   = '0;
              max_n   = '0;
              done_n  = 1'b0;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  assign bus.uo_out  = out_sel ? max_q : avg_q;
  assign bus.uio_out = {1'b0, busy, done_q, ready, 4'b0};
  assign bus.uio_oe  = 8'hF0;

endmodule

// File: tb/tb_sum_window_avg.sv
// Directed self-checking bench for sum_window_avg (WINDOW_LOG2=2).
// Expected values are hand-computed constants.
module tb_sum_window_avg;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  sum_window_avg_if bus ();

  sum_window_avg #(.WINDOW_LOG2(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%02h) expected %0d (0x%02h)",
               tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    bus.ui_in     = v;
    bus.uio_in[0] = 1'b1;
    step();
    bus.uio_in[0] = 1'b0;
  endtask

  task automatic do_ack();
    bus.uio_in[1] = 1'b1;
    step();
    bus.uio_in[1] = 1'b0;
  endtask

  task automatic peek(
    input string      tag,
    input logic [7:0] exp_avg,
    input logic [7:0] exp_max
  );
    bus.uio_in[3] = 1'b0;
    #1;
    check({tag, "_avg"}, bus.uo_out, exp_avg);
    bus.uio_in[3] = 1'b1;
    #1;
    check({tag, "_max"}, bus.uo_out, exp_max);
    bus.uio_in[3] = 1'b0;
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'd0;
    bus.uio_in = 8'hF0;
    step();
    step();
    check("rst_uo", bus.uo_out, 8'h00);
    check("rst_uio", bus.uio_out, 8'h10);
    check("rst_oe", bus.uio_oe, 8'hF0);
    rst_n = 1'b1;

    // 10,20,30,40 back to back
    send(8'd10);
    send(8'd20);
    send(8'd30);
    check("t1_mid", bus.uio_out, 8'h50);
    send(8'd40);
    check("t1_done", bus.uio_out, 8'h60);
    peek("t1", 8'd25, 8'd40);
    do_ack();
    check("t1_ack", bus.uio_out, 8'h10);
    peek("t1_keep", 8'd25, 8'd0);

    // 7/4 truncates to 1
    send(8'd1);
    send(8'd2);
    send(8'd2);
    send(8'd2);
    peek("t2", 8'd1, 8'd2);
    do_ack();

    // full-scale samples with gaps
    for (int i = 0; i < 4; i++) begin
      send(8'd255);
      step();
    end
    check("t3_done", bus.uio_out, 8'h60);
    peek("t3", 8'd255, 8'd255);
    do_ack();

    // HOLD ignores in_valid; ack wins over in_valid
    for (int i = 0; i < 4; i++) send(8'd12);
    bus.ui_in     = 8'd99;
    bus.uio_in[0] = 1'b1;
    step();
    step();
    step();
    check("t4_hold", bus.uio_out, 8'h60);
    peek("t4_hold", 8'd12, 8'd12);
    bus.uio_in[1] = 1'b1;
    step();
    bus.uio_in[1] = 1'b0;
    bus.uio_in[0] = 1'b0;
    check("t4_ack", bus.uio_out, 8'h10);
    peek("t4_ack", 8'd12, 8'd0);
    send(8'd8);
    send(8'd8);
    send(8'd8);
    check("t4_cnt", bus.uio_out, 8'h50);
    send(8'd8);
    check("t4_done", bus.uio_out, 8'h60);
    peek("t4_next", 8'd8, 8'd8);
    do_ack();

    // clear mid-window, no residue afterwards
    send(8'd5);
    send(8'd7);
    bus.uio_in[2] = 1'b1;
    bus.uio_in[0] = 1'b1;
    bus.ui_in     = 8'd77;
    step();
    bus.uio_in[2] = 1'b0;
    bus.uio_in[0] = 1'b0;
    check("t5_clr_uio", bus.uio_out, 8'h10);
    peek("t5_clr", 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) send(8'd4);
    check("t5_cnt", bus.uio_out, 8'h50);
    send(8'd4);
    peek("t5", 8'd4, 8'd4);
    do_ack();

    // reset in ACCUM, then ena gating and ack in ACCUM
    send(8'd50);
    send(8'd50);
    send(8'd50);
    rst_n = 1'b0;
    bus.uio_in[0] = 1'b1;
    step();
    rst_n = 1'b1;
    bus.uio_in[0] = 1'b0;
    check("t6_rst_uio", bus.uio_out, 8'h10);
    check("t6_rst_uo", bus.uo_out, 8'h00);
    send(8'd20);
    send(8'd20);
    bus.ena       = 1'b0;
    bus.ui_in     = 8'd200;
    bus.uio_in[0] = 1'b1;
    step();
    step();
    step();
    bus.uio_in[0] = 1'b0;
    bus.ena       = 1'b1;
    check("t6_ena", bus.uio_out, 8'h50);
    do_ack();
    check("t6_ack_acc", bus.uio_out, 8'h50);
    send(8'd20);
    check("t6_cnt", bus.uio_out, 8'h50);
    send(8'd20);
    check("t6_done", bus.uio_out, 8'h60);
    peek("t6", 8'd20, 8'd20);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
